// File: rtl/ram_arbiter.sv
// ram_arbiter: single-port owner of system RAM banks 0/1, shared between
// the 7800 system bus, a host port and the fill sweep. Optional macro: RAM_ARB_STARVE_EN.
module ram_arbiter #(
    parameter logic [7:0] FILL         = 8'hFF,
    parameter int         STARVE_LIMIT = 16
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        loading,
    input  logic        clear_start,
    input  logic        sys_ram0_cs,
    input  logic        sys_ram1_cs,
    input  logic [10:0] sys_addr,
    input  logic        sys_we,
    input  logic [7:0]  sys_wdata,
    output logic [7:0]  sys_rdata,
    input  logic        dma_active,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [11:0] host_addr,
    input  logic [7:0]  host_wdata,
    output logic [7:0]  host_rdata,
    output logic        host_ack,
    output logic [10:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram0_we,
    output logic        ram1_we,
    input  logic [7:0]  ram0_q,
    input  logic [7:0]  ram1_q,
    output logic        clear_busy,
    output logic        cpu_hold
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_HOST  = 2'd2;

    logic [1:0]  state;
    logic [10:0] clr_cnt;
    logic        loading_q;
    logic        sel1_q;
    logic        host_bank_q;
    logic [7:0]  host_rdata_q;
    logic [7:0]  host_q;
    logic        sys_cs;
    logic        clear_trig;
    logic        grant;
    logic        in_clear;

    assign sys_cs     = sys_ram0_cs | sys_ram1_cs;
    assign clear_trig = clear_start | (loading & ~loading_q);
    assign in_clear   = (state == S_CLEAR);
    assign grant      = (state == S_IDLE) & ~sys_cs & host_req & ~clear_trig;
    assign host_q     = host_bank_q ? ram1_q : ram0_q;
    assign host_ack   = (state == S_HOST);
    assign host_rdata = host_ack ? host_q : host_rdata_q;
    assign clear_busy = in_clear;

    // State sequencing, sweep counter and registered bank/read-data capture
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state        <= S_IDLE;
            clr_cnt      <= '0;
            loading_q    <= 1'b0;
            sel1_q       <= 1'b0;
            host_bank_q  <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            loading_q <= loading;
            sel1_q    <= sys_ram1_cs;
            unique case (state)
                S_IDLE: begin
                    if (clear_trig) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                    end else if (grant) begin
                        state       <= S_HOST;
                        host_bank_q <= host_addr[11];
                    end
                end
                S_CLEAR: begin
                    if (clear_start)
                        clr_cnt <= '0;
                    else if (clr_cnt == 11'h7FF && !loading)
                        state <= S_IDLE;
                    else
                        clr_cnt <= clr_cnt + 11'd1;
                end
                S_HOST: begin
                    host_rdata_q <= host_q;
                    if (clear_trig) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM port mux: sweep first, then system bus, then a host grant
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram0_we   = 1'b0;
        ram1_we   = 1'b0;
        sys_rdata = sel1_q ? ram1_q : ram0_q;
        if (in_clear) begin
            ram_addr  = clr_cnt;
            ram_wdata = FILL;
            ram0_we   = 1'b1;
            ram1_we   = 1'b1;
            sys_rdata = FILL;
        end else if (sys_cs) begin
            ram_addr  = sys_addr;
            ram_wdata = sys_wdata;
            ram0_we   = sys_ram0_cs & sys_we;
            ram1_we   = sys_ram1_cs & sys_we;
        end else if (grant) begin
            ram_addr  = host_addr[10:0];
            ram_wdata = host_wdata;
            ram0_we   = ~host_addr[11] & host_we;
            ram1_we   = host_addr[11] & host_we;
        end
    end

`ifdef RAM_ARB_STARVE_EN
    localparam int WW = $clog2(STARVE_LIMIT + 1);

    logic [WW-1:0] wait_cnt;
    logic          hold_q;
    logic          waiting;
    logic          reached;
    logic          hold_set;

    assign waiting  = (state == S_IDLE) & host_req & ~grant;
    assign reached  = int'(wait_cnt) >= STARVE_LIMIT - 1;
    assign hold_set = waiting & ~dma_active & reached;
    assign cpu_hold = (hold_q | hold_set) & ~dma_active;

    // Starvation counter: the cycle it reaches the limit raises the CPU hold
    always_ff @(posedge clk_sys) begin
        if (rst || grant)
            wait_cnt <= '0;
        else if (waiting && int'(wait_cnt) < STARVE_LIMIT)
            wait_cnt <= wait_cnt + 1'b1;
        if (rst || host_ack)
            hold_q <= 1'b0;
        else if (hold_set)
            hold_q <= 1'b1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = dma_active | (STARVE_LIMIT < 0);
    assign cpu_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and random checks of ram_arbiter against a
// byte-array shadow of both banks; the starvation test runs with RAM_ARB_STARVE_EN.
module tb_ram_arbiter;

    logic        clk_sys = 1'b0;
    logic        rst = 1'b1;
    logic        loading = 1'b0;
    logic        clear_start = 1'b0;
    logic        sys_ram0_cs = 1'b0;
    logic        sys_ram1_cs = 1'b0;
    logic [10:0] sys_addr = '0;
    logic        sys_we = 1'b0;
    logic [7:0]  sys_wdata = '0;
    logic [7:0]  sys_rdata;
    logic        dma_active = 1'b0;
    logic        host_req = 1'b0;
    logic        host_we = 1'b0;
    logic [11:0] host_addr = '0;
    logic [7:0]  host_wdata = '0;
    logic [7:0]  host_rdata;
    logic        host_ack;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram0_we;
    logic        ram1_we;
    logic [7:0]  ram0_q;
    logic [7:0]  ram1_q;
    logic        clear_busy;
    logic        cpu_hold;

    localparam logic [7:0] FILL = 8'hFF;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem0 [2048];
    logic [7:0] mem1 [2048];
    logic [7:0] sh   [2][2048];

    ram_arbiter dut (
        .clk_sys(clk_sys), .rst(rst), .loading(loading),
        .clear_start(clear_start),
        .sys_ram0_cs(sys_ram0_cs), .sys_ram1_cs(sys_ram1_cs),
        .sys_addr(sys_addr), .sys_we(sys_we), .sys_wdata(sys_wdata),
        .sys_rdata(sys_rdata), .dma_active(dma_active),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata),
        .host_ack(host_ack), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram0_we(ram0_we), .ram1_we(ram1_we),
        .ram0_q(ram0_q), .ram1_q(ram1_q),
        .clear_busy(clear_busy), .cpu_hold(cpu_hold)
    );

    always #5 clk_sys = ~clk_sys;

    // Two single-port RAMs with one-cycle read latency
    always @(posedge clk_sys) begin
        if (ram0_we) mem0[ram_addr] <= ram_wdata;
        if (ram1_we) mem1[ram_addr] <= ram_wdata;
        ram0_q <= mem0[ram_addr];
        ram1_q <= mem1[ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic host_op(input bit we, input logic [11:0] a,
                           input logic [7:0] d,
                           output logic [7:0] q, output int lat);
        tick();
        host_req = 1'b1;
        host_we = we;
        host_addr = a;
        host_wdata = d;
        lat = 0;
        do begin
            tick();
            lat++;
            #1;
        end while (!host_ack && lat < 50);
        q = host_rdata;
        host_req = 1'b0;
        host_we = 1'b0;
    endtask

    task automatic sys_wr(input logic b, input logic [10:0] a,
                          input logic [7:0] d);
        tick();
        sys_ram0_cs = ~b;
        sys_ram1_cs = b;
        sys_addr = a;
        sys_we = 1'b1;
        sys_wdata = d;
        tick();
        sys_ram0_cs = 1'b0;
        sys_ram1_cs = 1'b0;
        sys_we = 1'b0;
    endtask

    task automatic sys_rd(input logic b, input logic [10:0] a,
                          output logic [7:0] q);
        tick();
        sys_ram0_cs = ~b;
        sys_ram1_cs = b;
        sys_addr = a;
        sys_we = 1'b0;
        tick();
        #1;
        q = sys_rdata;
        sys_ram0_cs = 1'b0;
        sys_ram1_cs = 1'b0;
    endtask

    // Counts busy cycles; optionally restarts or attempts a system write
    task automatic busy_run(input int restart_at, input bit poke,
                            output int n);
        n = 0;
        while (clear_busy && n < 8000) begin
            n++;
            clear_start = (n == restart_at);
            if (poke && n >= 1500 && n < 1504) begin
                sys_ram0_cs = 1'b1;
                sys_we = 1'b1;
                sys_addr = 11'h123;
                sys_wdata = 8'h12;
                #1;
                chk("sweep_sys_rdata", sys_rdata, FILL);
            end else begin
                sys_ram0_cs = 1'b0;
                sys_we = 1'b0;
            end
            tick();
        end
        clear_start = 1'b0;
        sys_ram0_cs = 1'b0;
        sys_we = 1'b0;
    endtask

    task automatic fill_shadow();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 2048; a++)
                sh[b][a] = FILL;
    endtask

    initial begin
        logic [7:0] q;
        int lat;
        int n;
        int bad;
        int hbad;
        logic b;
        logic [10:0] a;
        logic [7:0] d;
        int op;

        for (int i = 0; i < 2048; i++) begin
            mem0[i] = 8'($urandom);
            mem1[i] = 8'($urandom);
        end

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_clear_busy", clear_busy, 0);
        chk("rst_host_ack", host_ack, 0);
        chk("rst_we", {ram0_we, ram1_we}, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_host_rdata", host_rdata, 0);
        chk("rst_cpu_hold", cpu_hold, 0);

        // Host write then read at 0x0A5
        host_op(1'b1, 12'h0A5, 8'h3C, q, lat);
        chk("hw_latency", lat, 1);
        host_op(1'b0, 12'h0A5, 8'h00, q, lat);
        chk("hr_latency", lat, 1);
        chk("hr_data", q, 8'h3C);
        tick();
        chk("hr_held", host_rdata, 8'h3C);
        chk("hr_ack_pulse", host_ack, 0);

        // Full sweep from clear_start, with a discarded system write
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        busy_run(0, 1'b1, n);
        chk("sweep_len", n, 2048);
        chk("sweep_done", clear_busy, 0);
        fill_shadow();
        bad = 0;
        for (int bk = 0; bk < 2; bk++)
            for (int ad = 0; ad < 2048; ad++) begin
                host_op(1'b0, {1'(bk), 11'(ad)}, 8'h00, q, lat);
                if (q !== FILL || lat != 1) bad++;
            end
        chk("sweep_all_ff", bad, 0);

        // Host request held off by a continuous RAM1 select
        tick();
        sys_ram1_cs = 1'b1;
        sys_addr = 11'h010;
        sys_we = 1'b1;
        sys_wdata = 8'h77;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 12'h810;
        #1;
        bad = 0;
        hbad = 0;
        for (int w = 1; w <= 20; w++) begin
            if (host_ack) bad++;
`ifdef RAM_ARB_STARVE_EN
            if (cpu_hold !== (w >= 16)) hbad++;
`endif
            tick();
            sys_we = 1'b0;
        end
        chk("cs_blocks_host", bad, 0);
`ifdef RAM_ARB_STARVE_EN
        chk("starve_hold_rise", hbad, 0);
`endif
        sys_ram1_cs = 1'b0;
        tick();
        #1;
        chk("cs_drop_ack", host_ack, 1);
        chk("cs_sys_write", host_rdata, 8'h77);
        host_req = 1'b0;
        sh[1][11'h010] = 8'h77;
        tick();
        chk("cs_ack_gone", host_ack, 0);
        chk("hold_cleared", cpu_hold, 0);

        // Sweep restart from clear_start after 1000 busy cycles
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        busy_run(1000, 1'b0, n);
        chk("restart_len", n, 1000 + 2048);

        // Loading held for 5000 cycles: sweep wraps, then finishes the pass
        tick();
        loading = 1'b1;
        tick();
        bad = 0;
        for (int i = 0; i < 5000; i++) begin
            if (!clear_busy) bad++;
            tick();
        end
        chk("load_busy", bad, 0);
        loading = 1'b0;
        busy_run(0, 1'b0, n);
        chk("load_tail", n, 2048 - (5000 % 2048));
        fill_shadow();
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            b = 1'($urandom);
            a = 11'($urandom);
            sys_rd(b, a, q);
            if (q !== FILL) bad++;
        end
        chk("load_spot_ff", bad, 0);

        // Random mix of host and system traffic against the shadow
        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 3));
            b = 1'($urandom);
            a = 11'($urandom);
            d = 8'($urandom);
            unique case (op)
                0: begin
                    host_op(1'b1, {b, a}, d, q, lat);
                    chk("rnd_hw_lat", lat, 1);
                    sh[b][a] = d;
                end
                1: begin
                    host_op(1'b0, {b, a}, 8'h00, q, lat);
                    chk("rnd_hr_lat", lat, 1);
                    chk("rnd_hr_data", q, sh[b][a]);
                end
                2: begin
                    sys_wr(b, a, d);
                    sh[b][a] = d;
                end
                default: begin
                    sys_rd(b, a, q);
                    chk("rnd_sr_data", q, sh[b][a]);
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
